// File: rtl/input_arbiter_rr_pkg.sv
// Shared constants, FSM state encoding and the round-robin select helper
// for the four-port packet arbiter.
package arbiter_pkg;

   localparam int NUM_PORTS     = 4;
   localparam int PORT_IDX_W    = 2;

   localparam int DEF_DATA_W    = 256;
   localparam int DEF_LEN_W     = 14;
   localparam int DEF_INPORT_W  = 3;
   localparam int DEF_OUTPORT_W = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arbState_t;

   // Scan last+1 .. last+4 (mod 4); the port just served is checked last.
   function automatic logic [PORT_IDX_W-1:0] rrSelect(
      input logic [NUM_PORTS-1:0]  valid,
      input logic [PORT_IDX_W-1:0] lastGrant
   );
      logic [PORT_IDX_W-1:0] pick;
      logic [PORT_IDX_W-1:0] idx;
      logic                  found;
      pick  = lastGrant;
      found = 1'b0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx = lastGrant + PORT_IDX_W'(i);
         if (!found && valid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/input_arbiter_rr_if.sv
// AXI4-Stream bundle with the switch tuser sideband; master drives the
// beat, slave returns tready.
interface axis_if
   import arbiter_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int LEN_W     = DEF_LEN_W,
   parameter int INPORT_W  = DEF_INPORT_W,
   parameter int OUTPORT_W = DEF_OUTPORT_W
);

   logic [DATA_W-1:0]    tdata;
   logic [DATA_W/8-1:0]  tkeep;
   logic [LEN_W-1:0]     tuser_packet_length;
   logic [INPORT_W-1:0]  tuser_in_port;
   logic [OUTPORT_W-1:0] tuser_out_port;
   logic [INPORT_W-1:0]  tuser_in_vport;
   logic [OUTPORT_W-1:0] tuser_out_vport;
   logic                 tvalid;
   logic                 tready;
   logic                 tlast;

   modport master (
      output tdata, tkeep, tuser_packet_length, tuser_in_port, tuser_out_port,
             tuser_in_vport, tuser_out_vport, tvalid, tlast,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tuser_packet_length, tuser_in_port, tuser_out_port,
             tuser_in_vport, tuser_out_vport, tvalid, tlast,
      output tready
   );

endinterface

// File: rtl/input_arbiter_rr_skid.sv
// Two-entry AXI-Stream register slice: a main output register plus a skid
// register that catches the one beat in flight when the sink stalls.
module axis_skid_reg
   import arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_resetn,
   input  logic             i_sValid,
   output logic             o_sReady,
   input  logic [WIDTH-1:0] i_sData,
   output logic             o_mValid,
   input  logic             i_mReady,
   output logic [WIDTH-1:0] o_mData
);

   logic             r_mainValid;
   logic [WIDTH-1:0] r_mainData;
   logic             r_skidValid;
   logic [WIDTH-1:0] r_skidData;
   logic             w_mainLoad;
   logic             w_inFire;

   // Upstream ready is purely registered: accept whenever the skid slot is free.
   assign o_sReady   = !r_skidValid;
   assign w_inFire   = i_sValid && !r_skidValid;
   assign w_mainLoad = i_mReady || !r_mainValid;

   assign o_mValid = r_mainValid;
   assign o_mData  = r_mainData;

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_mainValid <= 1'b0;
         r_mainData  <= '0;
         r_skidValid <= 1'b0;
         r_skidData  <= '0;
      end else if (w_mainLoad) begin
         if (r_skidValid) begin
            r_mainValid <= 1'b1;
            r_mainData  <= r_skidData;
            r_skidValid <= 1'b0;
         end else begin
            r_mainValid <= w_inFire;
            if (w_inFire) begin
               r_mainData <= i_sData;
            end
         end
      end else if (w_inFire) begin
         r_skidValid <= 1'b1;
         r_skidData  <= i_sData;
      end
   end

endmodule

// File: rtl/input_arbiter_rr.sv
// Four-port packet-granular round-robin arbiter: merges the port streams,
// stamps tuser_in_port with the winner and registers the result.
module input_arbiter_rr
   import arbiter_pkg::*;
#(
   parameter int C_AXIS_DATA_WIDTH     = DEF_DATA_W,
   parameter int C_PACKET_LENGTH_WIDTH = DEF_LEN_W,
   parameter int C_INPORT_WIDTH        = DEF_INPORT_W,
   parameter int C_OUTPORT_WIDTH       = DEF_OUTPORT_W
) (
   input  logic   axi_aclk,
   input  logic   axi_resetn,
   axis_if.slave  port0_s_axis,
   axis_if.slave  port1_s_axis,
   axis_if.slave  port2_s_axis,
   axis_if.slave  port3_s_axis,
   axis_if.master arbiter_m_axis
);

   localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;

   typedef struct packed {
      logic [C_AXIS_DATA_WIDTH-1:0]     data;
      logic [KEEP_W-1:0]                keep;
      logic [C_PACKET_LENGTH_WIDTH-1:0] len;
      logic [C_INPORT_WIDTH-1:0]        inPort;
      logic [C_OUTPORT_WIDTH-1:0]       outPort;
      logic [C_INPORT_WIDTH-1:0]        inVport;
      logic [C_OUTPORT_WIDTH-1:0]       outVport;
      logic                             last;
   } beat_t;

   beat_t                 w_inBeat [NUM_PORTS];
   logic [NUM_PORTS-1:0]  w_inValid;
   logic [NUM_PORTS-1:0]  w_inReady;

   arbState_t             r_state;
   arbState_t             w_stateNext;
   logic [PORT_IDX_W-1:0] r_lastGrant;
   logic [PORT_IDX_W-1:0] w_lastGrantNext;
   logic [PORT_IDX_W-1:0] r_heldGrant;
   logic [PORT_IDX_W-1:0] w_heldGrantNext;
   logic [PORT_IDX_W-1:0] w_grant;
   logic                  w_selValid;
   logic                  w_accept;
   logic                  w_bufReady;
   beat_t                 w_selBeat;
   beat_t                 w_outBeat;

   assign w_inValid = {port3_s_axis.tvalid, port2_s_axis.tvalid,
                       port1_s_axis.tvalid, port0_s_axis.tvalid};

   assign w_inBeat[0] = {port0_s_axis.tdata, port0_s_axis.tkeep,
                         port0_s_axis.tuser_packet_length, port0_s_axis.tuser_in_port,
                         port0_s_axis.tuser_out_port, port0_s_axis.tuser_in_vport,
                         port0_s_axis.tuser_out_vport, port0_s_axis.tlast};
   assign w_inBeat[1] = {port1_s_axis.tdata, port1_s_axis.tkeep,
                         port1_s_axis.tuser_packet_length, port1_s_axis.tuser_in_port,
                         port1_s_axis.tuser_out_port, port1_s_axis.tuser_in_vport,
                         port1_s_axis.tuser_out_vport, port1_s_axis.tlast};
   assign w_inBeat[2] = {port2_s_axis.tdata, port2_s_axis.tkeep,
                         port2_s_axis.tuser_packet_length, port2_s_axis.tuser_in_port,
                         port2_s_axis.tuser_out_port, port2_s_axis.tuser_in_vport,
                         port2_s_axis.tuser_out_vport, port2_s_axis.tlast};
   assign w_inBeat[3] = {port3_s_axis.tdata, port3_s_axis.tkeep,
                         port3_s_axis.tuser_packet_length, port3_s_axis.tuser_in_port,
                         port3_s_axis.tuser_out_port, port3_s_axis.tuser_in_vport,
                         port3_s_axis.tuser_out_vport, port3_s_axis.tlast};

   assign port0_s_axis.tready = w_inReady[0];
   assign port1_s_axis.tready = w_inReady[1];
   assign port2_s_axis.tready = w_inReady[2];
   assign port3_s_axis.tready = w_inReady[3];

   // The pointer only moves on a completed packet, so a port keeps the
   // stream for its whole packet and then drops to lowest priority.
   always_comb begin
      w_grant         = r_heldGrant;
      w_selValid      = 1'b0;
      w_inReady       = '0;
      w_stateNext     = r_state;
      w_lastGrantNext = r_lastGrant;
      w_heldGrantNext = r_heldGrant;

      unique case (r_state)
         IDLE: begin
            w_grant    = rrSelect(w_inValid, r_lastGrant);
            w_selValid = |w_inValid;
         end
         LOCKED: begin
            w_grant    = r_heldGrant;
            w_selValid = w_inValid[r_heldGrant];
         end
         default: begin
            w_grant    = r_heldGrant;
            w_selValid = 1'b0;
         end
      endcase

      if (axi_resetn && ((r_state == LOCKED) || (|w_inValid))) begin
         w_inReady[w_grant] = w_bufReady;
      end

      w_accept         = w_selValid && w_bufReady;
      w_selBeat        = w_inBeat[w_grant];
      w_selBeat.inPort = C_INPORT_WIDTH'(w_grant);

      if (w_accept) begin
         if (w_selBeat.last) begin
            w_stateNext     = IDLE;
            w_lastGrantNext = w_grant;
         end else begin
            w_stateNext     = LOCKED;
            w_heldGrantNext = w_grant;
         end
      end
   end

   // Reset leaves the pointer on port3 so port0 wins the first arbitration.
   always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) begin
         r_state     <= IDLE;
         r_lastGrant <= PORT_IDX_W'(NUM_PORTS - 1);
         r_heldGrant <= '0;
      end else begin
         r_state     <= w_stateNext;
         r_lastGrant <= w_lastGrantNext;
         r_heldGrant <= w_heldGrantNext;
      end
   end

   axis_skid_reg #(
      .WIDTH ($bits(beat_t))
   ) uSkid (
      .i_clk    (axi_aclk),
      .i_resetn (axi_resetn),
      .i_sValid (w_selValid),
      .o_sReady (w_bufReady),
      .i_sData  (w_selBeat),
      .o_mValid (arbiter_m_axis.tvalid),
      .i_mReady (arbiter_m_axis.tready),
      .o_mData  (w_outBeat)
   );

   assign arbiter_m_axis.tdata               = w_outBeat.data;
   assign arbiter_m_axis.tkeep               = w_outBeat.keep;
   assign arbiter_m_axis.tuser_packet_length = w_outBeat.len;
   assign arbiter_m_axis.tuser_in_port       = w_outBeat.inPort;
   assign arbiter_m_axis.tuser_out_port      = w_outBeat.outPort;
   assign arbiter_m_axis.tuser_in_vport      = w_outBeat.inVport;
   assign arbiter_m_axis.tuser_out_vport     = w_outBeat.outVport;
   assign arbiter_m_axis.tlast               = w_outBeat.last;

endmodule

// File: tb/tb_input_arbiter_rr.sv
// Bench for input_arbiter_rr: arbitration vector table, packet sequences
// and a scoreboard that follows every accepted beat to the output.
module tb_input_arbiter_rr;
   import arbiter_pkg::*;

   localparam int DW  = 256;
   localparam int KW  = DW / 8;
   localparam int LW  = 14;
   localparam int IPW = 3;
   localparam int OPW = 8;

   typedef struct {
      logic [DW-1:0]  data;
      logic [KW-1:0]  keep;
      logic [LW-1:0]  len;
      logic [IPW-1:0] inPort;
      logic [OPW-1:0] outPort;
      logic [IPW-1:0] inVport;
      logic [OPW-1:0] outVport;
      logic           last;
      int             cyc;
   } beat_t;

   typedef struct {
      logic [3:0] validMask;
      logic [3:0] expReady;
   } vector_t;

   logic clk  = 1'b0;
   logic rstN = 1'b0;
   logic mReady;

   always #5 clk = ~clk;

   axis_if #(.DATA_W(DW), .LEN_W(LW), .INPORT_W(IPW), .OUTPORT_W(OPW)) pIf [4] ();
   axis_if #(.DATA_W(DW), .LEN_W(LW), .INPORT_W(IPW), .OUTPORT_W(OPW)) mIf ();

   logic [DW-1:0]  pData    [4];
   logic [KW-1:0]  pKeep    [4];
   logic [LW-1:0]  pLen     [4];
   logic [IPW-1:0] pInPort  [4];
   logic [OPW-1:0] pOutPort [4];
   logic [IPW-1:0] pInVport [4];
   logic [OPW-1:0] pOutVport[4];
   logic [3:0]     pValid;
   logic [3:0]     pLast;
   wire  [3:0]     pReady;

   generate
      for (genvar g = 0; g < 4; g++) begin : gPort
         assign pIf[g].tdata               = pData[g];
         assign pIf[g].tkeep               = pKeep[g];
         assign pIf[g].tuser_packet_length = pLen[g];
         assign pIf[g].tuser_in_port       = pInPort[g];
         assign pIf[g].tuser_out_port      = pOutPort[g];
         assign pIf[g].tuser_in_vport      = pInVport[g];
         assign pIf[g].tuser_out_vport     = pOutVport[g];
         assign pIf[g].tvalid              = pValid[g];
         assign pIf[g].tlast               = pLast[g];
         assign pReady[g]                  = pIf[g].tready;
      end
   endgenerate

   assign mIf.tready = mReady;

   input_arbiter_rr #(
      .C_AXIS_DATA_WIDTH     (DW),
      .C_PACKET_LENGTH_WIDTH (LW),
      .C_INPORT_WIDTH        (IPW),
      .C_OUTPORT_WIDTH       (OPW)
   ) dut (
      .axi_aclk       (clk),
      .axi_resetn     (rstN),
      .port0_s_axis   (pIf[0]),
      .port1_s_axis   (pIf[1]),
      .port2_s_axis   (pIf[2]),
      .port3_s_axis   (pIf[3]),
      .arbiter_m_axis (mIf)
   );

   int     testsRun    = 0;
   int     testsFailed = 0;
   int     cycle       = 0;
   int     outCount    = 0;
   bit     autoDrive   = 1'b0;
   bit     randomReady = 1'b0;
   bit     checkLatency = 1'b0;
   bit     stalledPrev = 1'b0;
   logic [DW-1:0] heldData;
   beat_t  monBeat;
   beat_t  expQ[$];
   beat_t  srcQ[4][$];
   int     grantLog[$];
   int     acceptCyc[$];

   task automatic checkOutput(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [255:0] packSide(
      input logic [KW-1:0] k, input logic [LW-1:0] l, input logic [IPW-1:0] ip,
      input logic [OPW-1:0] op, input logic [IPW-1:0] ivp, input logic [OPW-1:0] ovp,
      input logic last);
      return 256'({k, l, ip, op, ivp, ovp, last});
   endfunction

   function automatic beat_t makeBeat(input logic last);
      beat_t b;
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom();
      b.keep     = $urandom();
      b.len      = LW'($urandom());
      b.inPort   = IPW'($urandom());
      b.outPort  = OPW'($urandom());
      b.inVport  = IPW'($urandom());
      b.outVport = OPW'($urandom());
      b.last     = last;
      b.cyc      = 0;
      return b;
   endfunction

   task automatic driveBeat(input int i, input beat_t b);
      pData[i]     = b.data;
      pKeep[i]     = b.keep;
      pLen[i]      = b.len;
      pInPort[i]   = b.inPort;
      pOutPort[i]  = b.outPort;
      pInVport[i]  = b.inVport;
      pOutVport[i] = b.outVport;
      pLast[i]     = b.last;
   endtask

   task automatic pushPacket(input int port, input int n);
      for (int k = 0; k < n; k++) srcQ[port].push_back(makeBeat(k == n - 1));
   endtask

   task automatic present();
      for (int i = 0; i < 4; i++) begin
         if (srcQ[i].size() > 0) begin
            driveBeat(i, srcQ[i][0]);
            pValid[i] = 1'b1;
         end else begin
            pValid[i] = 1'b0;
         end
      end
   endtask

   // One clock: retire accepted source beats at the edge, re-drive 1 ns later.
   task automatic tick();
      @(posedge clk);
      if (autoDrive) begin
         for (int i = 0; i < 4; i++) begin
            if (pValid[i] && pReady[i]) srcQ[i].delete(0);
         end
      end
      #1;
      if (autoDrive) present();
      if (randomReady) mReady = ($urandom_range(0, 2) != 0);
   endtask

   function automatic bit anyPending();
      bit p = (expQ.size() != 0) || (pValid != 4'b0000);
      for (int i = 0; i < 4; i++) if (srcQ[i].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic waitDrain(input string name, input int budget);
      int n = 0;
      while (anyPending() && n < budget) begin
         tick();
         n++;
      end
      checkOutput({name, "_drain_timeout"}, 256'(anyPending()), 256'(0));
   endtask

   task automatic resetLogs();
      grantLog.delete();
      acceptCyc.delete();
   endtask

   task automatic checkOrder(input string name, input int n, input logic [63:0] expPacked);
      logic [63:0] act = '0;
      checkOutput({name, "_count"}, 256'(grantLog.size()), 256'(n));
      for (int k = 0; k < grantLog.size() && k < 32; k++) act[2*k +: 2] = 2'(grantLog[k]);
      checkOutput({name, "_order"}, 256'(act), 256'(expPacked));
   endtask

   task automatic checkSpan(input string name, input int n);
      int span = (acceptCyc.size() == n) ? (acceptCyc[n-1] - acceptCyc[0]) : -1;
      checkOutput({name, "_contiguous"}, 256'(span), 256'(n - 1));
   endtask

   // Scoreboard: push on input handshake, pop and compare on output handshake.
   always @(posedge clk) begin
      cycle++;
      if (!rstN) begin
         expQ.delete();
         stalledPrev = 1'b0;
      end else begin
         if (stalledPrev) begin
            checkOutput("stall_hold_valid", 256'(mIf.tvalid), 256'(1));
            checkOutput("stall_hold_data", mIf.tdata, heldData);
         end
         if (mIf.tvalid && mReady) begin
            checkOutput("beat_expected", 256'(expQ.size() != 0), 256'(1));
            if (expQ.size() != 0) begin
               monBeat = expQ.pop_front();
               checkOutput("out_data", mIf.tdata, monBeat.data);
               checkOutput("out_sideband",
                  packSide(mIf.tkeep, mIf.tuser_packet_length, mIf.tuser_in_port,
                           mIf.tuser_out_port, mIf.tuser_in_vport, mIf.tuser_out_vport,
                           mIf.tlast),
                  packSide(monBeat.keep, monBeat.len, monBeat.inPort, monBeat.outPort,
                           monBeat.inVport, monBeat.outVport, monBeat.last));
               if (checkLatency) checkOutput("latency", 256'(cycle - monBeat.cyc), 256'(1));
            end
            outCount++;
         end
         stalledPrev = mIf.tvalid && !mReady;
         heldData    = mIf.tdata;
         for (int i = 0; i < 4; i++) begin
            if (pValid[i] && pReady[i]) begin
               monBeat.data     = pData[i];
               monBeat.keep     = pKeep[i];
               monBeat.len      = pLen[i];
               monBeat.inPort   = IPW'(i);
               monBeat.outPort  = pOutPort[i];
               monBeat.inVport  = pInVport[i];
               monBeat.outVport = pOutVport[i];
               monBeat.last     = pLast[i];
               monBeat.cyc      = cycle;
               expQ.push_back(monBeat);
               grantLog.push_back(i);
               acceptCyc.push_back(cycle);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic applyStimulus();
      vector_t vecs[10];
      int n;
      // Single-beat packets, so the pointer moves after every accepted vector.
      vecs[0] = '{4'b1111, 4'b0001};
      vecs[1] = '{4'b1111, 4'b0010};
      vecs[2] = '{4'b1001, 4'b1000};
      vecs[3] = '{4'b0110, 4'b0010};
      vecs[4] = '{4'b0000, 4'b0000};
      vecs[5] = '{4'b0001, 4'b0001};
      vecs[6] = '{4'b0001, 4'b0001};
      vecs[7] = '{4'b1100, 4'b0100};
      vecs[8] = '{4'b1011, 4'b1000};
      vecs[9] = '{4'b0100, 4'b0100};

      pValid = 4'b0000;
      mReady = 1'b1;
      for (int i = 0; i < 4; i++) driveBeat(i, makeBeat(1'b0));

      // Reset with every input requesting: nobody may see tready.
      rstN   = 1'b0;
      pValid = 4'b1111;
      repeat (3) tick();
      @(negedge clk);
      checkOutput("reset_tready", 256'(pReady), 256'(0));
      checkOutput("reset_mvalid", 256'(mIf.tvalid), 256'(0));
      pValid = 4'b0000;
      tick();
      rstN = 1'b1;
      tick();
      @(negedge clk);
      checkOutput("idle_mvalid", 256'(mIf.tvalid), 256'(0));
      checkOutput("idle_tdata", mIf.tdata, 256'(0));
      checkOutput("idle_side", packSide(mIf.tkeep, mIf.tuser_packet_length, mIf.tuser_in_port,
                  mIf.tuser_out_port, mIf.tuser_in_vport, mIf.tuser_out_vport, mIf.tlast), 256'(0));
      checkOutput("idle_tready", 256'(pReady), 256'(0));
      tick();

      resetLogs();
      checkLatency = 1'b1;
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < 4; i++) driveBeat(i, makeBeat(1'b1));
         pValid = vecs[k].validMask;
         @(negedge clk);
         checkOutput($sformatf("vec%0d_tready", k), 256'(pReady), 256'(vecs[k].expReady));
         tick();
      end
      pValid = 4'b0000;
      repeat (3) tick();
      checkOrder("vec", 9, 64'h2E074);

      // Three-beat packet on port2.
      autoDrive = 1'b1;
      resetLogs();
      pushPacket(2, 3);
      waitDrain("p2", 100);
      checkOrder("p2", 3, 64'h2A);
      checkSpan("p2", 3);

      // All four ports with two-beat packets after reset.
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
      resetLogs();
      for (int p = 0; p < 4; p++) pushPacket(p, 2);
      waitDrain("all4", 100);
      checkOrder("all4", 8, 64'hFA50);
      checkSpan("all4", 8);

      // Port0 arrives while port1 is mid-packet and must wait its turn.
      resetLogs();
      pushPacket(1, 4);
      tick();
      tick();
      pushPacket(0, 2);
      tick();
      @(negedge clk);
      checkOutput("p0_valid_while_locked", 256'(pValid[0]), 256'(1));
      checkOutput("p0_blocked", 256'(pReady[0]), 256'(0));
      waitDrain("lock", 100);
      checkOrder("lock", 6, 64'h055);
   endtask

   task automatic checkOutputSequences();
      int n;
      // Long packet against a randomly stalling sink.
      resetLogs();
      checkLatency = 1'b0;
      outCount     = 0;
      randomReady  = 1'b1;
      pushPacket(1, 64);
      waitDrain("stall64", 2000);
      randomReady = 1'b0;
      mReady      = 1'b1;
      checkOutput("stall64_out_count", 256'(outCount), 256'(64));
      checkOutput("stall64_in_count", 256'(grantLog.size()), 256'(64));

      // One-cycle reset while port3 is locked mid-packet.
      resetLogs();
      checkLatency = 1'b1;
      pushPacket(3, 4);
      n = 0;
      while (grantLog.size() < 2 && n < 50) begin
         tick();
         n++;
      end
      checkOutput("p3_lock_timeout", 256'(grantLog.size() >= 2), 256'(1));
      rstN = 1'b0;
      pushPacket(0, 1);
      tick();
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("rst_pulse_mvalid", 256'(mIf.tvalid), 256'(0));
      checkOutput("rst_pulse_tready", 256'(pReady), 256'(4'b0001));
      waitDrain("rst_pulse", 100);
      checkOrder("rst_pulse", 5, 64'h3CF);
      checkOutput("final_scoreboard_empty", 256'(expQ.size()), 256'(0));
   endtask

   initial begin
      applyStimulus();
      checkOutputSequences();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
